// File: rtl/cic_comb_delay_m256_pkg.sv
// Shared defaults and state encoding for the CIC comb delay-line slice.
// The top module and the testbench both import this package.
package cic_comb_delay_m256_pkg;

  localparam int DEFAULT_DELAY    = 256;
  localparam int DEFAULT_DATA_W   = 48;
  localparam int DEFAULT_COMB_LAT = 4;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } comb_state_e;

endpackage

// File: rtl/comb_delay_ram.sv
// Simple dual-port buffer with a registered, read-first read port.
// It has no reset, so it can map onto block RAM; the owner clears it by sweeping zero writes.
module comb_delay_ram #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 48,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // When read and write hit the same address, the non-blocking write returns the old word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/cic_comb_delay_m256.sv
// Differential-delay line for a CIC comb. It presents each accepted sample and the sample
// accepted DELAY beats earlier, and it gives a strobe aligned to the comb's P output.
module cic_comb_delay_m256
  import cic_comb_delay_m256_pkg::*;
#(
  parameter int DELAY    = DEFAULT_DELAY,
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int COMB_LAT = DEFAULT_COMB_LAT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              s_tvalid,
  input  logic [DATA_W-1:0] s_tdata,
  output logic              s_tready,
  output logic [DATA_W-1:0] cur_data,
  output logic [DATA_W-1:0] dly_data,
  output logic              cur_valid,
  output logic              p_valid
);

  localparam int PTR_W = $clog2(DELAY);

  comb_state_e       state;
  logic [PTR_W-1:0]  clr_cnt;
  logic [PTR_W-1:0]  wptr;
  logic              accept;
  logic              acc_d1;
  logic              ram_we;
  logic [PTR_W-1:0]  ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [COMB_LAT-1:0] pv_pipe;

  assign accept  = s_tvalid & s_tready;
  assign p_valid = pv_pipe[COMB_LAT-1];

  // During CLEAR the write port sweeps zeros so no stale sample can reach dly_data.
  always_comb begin
    ram_we    = accept;
    ram_waddr = wptr;
    ram_wdata = s_tdata;
    if (state == CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = clr_cnt;
      ram_wdata = '0;
    end
  end

  comb_delay_ram #(
    .DEPTH (DELAY),
    .DATA_W(DATA_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .re   (accept),
    .raddr(wptr),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= CLEAR;
      clr_cnt  <= '0;
      s_tready <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == PTR_W'(DELAY - 1)) begin
            state    <= RUN;
            s_tready <= 1'b1;
          end
        end
        RUN: s_tready <= 1'b1;
      endcase
    end
  end

  // The buffer read lands one clock after the beat, so dly_data trails cur_data by one clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr      <= '0;
      cur_data  <= '0;
      dly_data  <= '0;
      cur_valid <= 1'b0;
      acc_d1    <= 1'b0;
      pv_pipe   <= '0;
    end else begin
      cur_valid <= accept;
      acc_d1    <= accept;
      if (accept) begin
        wptr     <= wptr + 1'b1;
        cur_data <= s_tdata;
      end
      if (acc_d1) dly_data <= ram_rdata;
      pv_pipe[0] <= cur_valid;
      for (int i = 1; i < COMB_LAT; i++) pv_pipe[i] <= pv_pipe[i-1];
    end
  end

endmodule

// File: tb/tb_cic_comb_delay_m256.sv
// Scoreboard bench for cic_comb_delay_m256. The driver queues the expected beats, and a
// separate monitor checks cur/dly/p_valid whenever the DUT presents them.
module tb_cic_comb_delay_m256;
  import cic_comb_delay_m256_pkg::*;

  localparam int DELAY    = DEFAULT_DELAY;
  localparam int DATA_W   = DEFAULT_DATA_W;
  localparam int COMB_LAT = DEFAULT_COMB_LAT;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              s_tvalid;
  logic [DATA_W-1:0] s_tdata;
  logic              s_tready;
  logic [DATA_W-1:0] cur_data;
  logic [DATA_W-1:0] dly_data;
  logic              cur_valid;
  logic              p_valid;

  typedef struct {
    logic [DATA_W-1:0] cur;
    logic [DATA_W-1:0] dly;
    int                acc;
  } beat_t;

  typedef struct {
    logic [DATA_W-1:0] exp_p;
    logic [DATA_W-1:0] act_p;
    int                due;
  } pres_t;

  beat_t             expq[$];
  pres_t             pq[$];
  logic [DATA_W-1:0] hist[$];
  logic [DATA_W-1:0] act_cur[512];
  logic [DATA_W-1:0] act_dly[512];

  int  cyc = 0;
  int  errors = 0;
  int  checks = 0;
  int  nacc = 0;
  int  seq = 0;
  int  pend_seq = 0;
  bit  dly_pending = 1'b0;
  bit  took;
  beat_t             pend;
  logic [DATA_W-1:0] pend_cur_act = '0;
  logic [DATA_W-1:0] last_cur_exp = '0;
  logic [DATA_W-1:0] last_dly_exp = '0;

  cic_comb_delay_m256 #(
    .DELAY   (DELAY),
    .DATA_W  (DATA_W),
    .COMB_LAT(COMB_LAT)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .s_tvalid (s_tvalid),
    .s_tdata  (s_tdata),
    .s_tready (s_tready),
    .cur_data (cur_data),
    .dly_data (dly_data),
    .cur_valid(cur_valid),
    .p_valid  (p_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // The model's expected dly is the sample accepted DELAY beats ago, or zero while the line fills.
  task automatic apply_stimulus(input bit v, input logic [DATA_W-1:0] d, output bit accepted);
    beat_t b;
    @(posedge clk);
    #1;
    s_tvalid = v;
    s_tdata  = d;
    accepted = v && (s_tready === 1'b1);
    if (accepted) begin
      b.cur = d;
      b.dly = (hist.size() >= DELAY) ? hist[hist.size() - DELAY] : '0;
      b.acc = cyc + 1;
      expq.push_back(b);
      hist.push_back(d);
      nacc++;
    end
  endtask

  task automatic assert_reset();
    reset_n      = 1'b0;
    s_tvalid     = 1'b0;
    expq.delete();
    pq.delete();
    hist.delete();
    nacc         = 0;
    seq          = 0;
    dly_pending  = 1'b0;
    last_cur_exp = '0;
    last_dly_exp = '0;
  endtask

  task automatic release_reset();
    int n;
    @(posedge clk);
    #1;
    reset_n  = 1'b1;
    s_tvalid = 1'b1;
    s_tdata  = 48'hDEAD_BEEF_0001;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (s_tready !== 1'b1 && n < 1000);
    s_tvalid = 1'b0;
    check_output("clear_clocks", 64'(n), 64'(DELAY));
  endtask

  task automatic idle(input int n);
    bit t;
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, '0, t);
  endtask

  // The monitor samples on the falling edge, well away from the edge that updates the DUT.
  always @(negedge clk) begin
    if (!reset_n) begin
      check_output("rst_cur_valid", 64'(cur_valid), 64'(0));
      check_output("rst_p_valid", 64'(p_valid), 64'(0));
      check_output("rst_cur_data", 64'(cur_data), 64'(0));
      check_output("rst_dly_data", 64'(dly_data), 64'(0));
    end else begin
      if (dly_pending) begin
        pres_t pr;
        check_output("dly_data", 64'(dly_data), 64'(pend.dly));
        if (pend_seq < 512) act_dly[pend_seq] = dly_data;
        last_dly_exp = pend.dly;
        pr.exp_p = pend.cur - pend.dly;
        pr.act_p = pend_cur_act - dly_data;
        pr.due   = pend.acc + COMB_LAT;
        pq.push_back(pr);
        dly_pending = 1'b0;
      end else begin
        check_output("dly_data_hold", 64'(dly_data), 64'(last_dly_exp));
      end

      if (cur_valid) begin
        if (expq.size() == 0) begin
          check_output("cur_valid_unexpected", 64'(1), 64'(0));
        end else begin
          pend = expq.pop_front();
          check_output("cur_valid_cycle", 64'(cyc), 64'(pend.acc));
          check_output("cur_data", 64'(cur_data), 64'(pend.cur));
          if (seq < 512) act_cur[seq] = cur_data;
          pend_seq     = seq;
          seq++;
          pend_cur_act = cur_data;
          last_cur_exp = pend.cur;
          dly_pending  = 1'b1;
        end
      end else begin
        check_output("cur_data_hold", 64'(cur_data), 64'(last_cur_exp));
      end

      begin
        bit exp_pv;
        pres_t pr;
        exp_pv = (pq.size() > 0) && (pq[0].due == cyc);
        check_output("p_valid_timing", 64'(p_valid), 64'(exp_pv));
        if (p_valid && exp_pv) begin
          pr = pq.pop_front();
          check_output("comb_p", 64'(pr.act_p), 64'(pr.exp_p));
        end else if (!p_valid && pq.size() > 0 && pq[0].due <= cyc) begin
          void'(pq.pop_front());
        end
      end
    end
  end

  initial begin
    #2000000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int n_gap;
    int budget;
    logic [DATA_W-1:0] d;

    reset_n  = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    repeat (3) @(posedge clk);
    release_reset();

    // Continuous fill: beat k carries k+1.
    for (int k = 0; k < 512; k++) begin
      apply_stimulus(1'b1, 48'(k + 1), took);
      check_output("fill_accept", 64'(took), 64'(1));
    end
    idle(6);
    check_output("wptr_after_fill", 64'(dut.wptr), 64'(nacc % DELAY));
    check_output("beat0_cur", 64'(act_cur[0]), 64'd1);
    check_output("beat0_dly", 64'(act_dly[0]), 64'd0);
    check_output("beat255_cur", 64'(act_cur[255]), 64'd256);
    check_output("beat255_dly", 64'(act_dly[255]), 64'd0);
    check_output("beat256_cur", 64'(act_cur[256]), 64'd257);
    check_output("beat256_dly", 64'(act_dly[256]), 64'd1);
    check_output("beat257_dly", 64'(act_dly[257]), 64'd2);
    check_output("beat511_cur", 64'(act_cur[511]), 64'd512);
    check_output("beat511_dly", 64'(act_dly[511]), 64'd256);

    // A lone beat shows the cur -> dly -> p_valid alignment.
    apply_stimulus(1'b1, 48'h0000_1234_5678, took);
    idle(8);

    // Random gaps at about 30% valid duty.
    n_gap  = 0;
    budget = 0;
    while (n_gap < 1000 && budget < 20000) begin
      d = 48'({$urandom, $urandom});
      apply_stimulus($urandom_range(0, 99) < 30, d, took);
      if (took) n_gap++;
      budget++;
    end
    check_output("gap_beats_done", 64'(n_gap), 64'd1000);
    idle(6);
    check_output("wptr_after_gaps", 64'(dut.wptr), 64'(nacc % DELAY));

    // Reset in the middle of a stream while p_valid strobes are still in flight.
    for (int k = 0; k < 300; k++) apply_stimulus(1'b1, 48'h5000_0000_0000 + 48'(k), took);
    @(posedge clk);
    #1;
    check_output("p_valid_in_flight", 64'(p_valid), 64'd1);
    assert_reset();
    #1;
    check_output("p_valid_drop", 64'(p_valid), 64'd0);
    repeat (2) @(posedge clk);
    release_reset();
    for (int k = 0; k < 300; k++) apply_stimulus(1'b1, 48'h6000_0000_0000 + 48'(k), took);
    idle(8);
    check_output("wptr_after_rst", 64'(dut.wptr), 64'(nacc % DELAY));
    check_output("rst_fill_dly0", 64'(act_dly[0]), 64'd0);
    check_output("rst_fill_dly255", 64'(act_dly[255]), 64'd0);
    check_output("rst_fill_dly256", 64'(act_dly[256]), 64'h6000_0000_0000);

    check_output("expq_drained", 64'(expq.size()), 64'd0);
    check_output("pq_drained", 64'(pq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cic_comb_delay_m256.md
CIC_COMB_DELAY_M256 -- requirements
Module: cic_comb_delay_M256

Interface
REQ-001 SHALL provide parameter DELAY, default 256, comb differential delay M in accepted samples, power of two.
REQ-002 SHALL provide parameter DATA_W, default 48, sample width in bits.
REQ-003 SHALL provide parameter COMB_LAT, default 4, clocks from cur_data to the comb P output.
REQ-004 SHALL provide port clk, input, 1, sole clock; all logic on rising edge.
REQ-005 SHALL provide port reset_n, input, 1; reset is asynchronous and active-low.
REQ-006 SHALL provide port s_tvalid, input, 1, upstream (integrator) sample valid.
REQ-007 SHALL provide port s_tdata, input, DATA_W, upstream sample.
REQ-008 SHALL provide port s_tready, output, 1, high only in RUN state.
REQ-009 SHALL provide port cur_data, output, DATA_W, current sample, drives comb c.
REQ-010 SHALL provide port dly_data, output, DATA_W, sample from DELAY beats earlier, drives comb concat.
REQ-011 SHALL provide port cur_valid, output, 1, strobe qualifying cur_data.
REQ-012 SHALL provide port p_valid, output, 1, strobe marking a valid comb P result.

Function
REQ-013 SHALL accept a beat only in the cycle where s_tvalid and s_tready are both high; there is no downstream backpressure.
REQ-014 SHALL store samples in a DELAY x DATA_W circular buffer with an 8-bit (log2 DELAY) write pointer that wraps 255->0 and advances only on an accepted beat.
REQ-015 SHALL, on a beat accepted at cycle T, read buffer[wptr] read-before-write and write s_tdata to buffer[wptr] in the same cycle.
REQ-016 SHALL register s_tdata to cur_data and pulse cur_valid at T+1.
REQ-017 SHALL present the old buffer word on dly_data at T+2, one clock after cur_data, matching the comb's c path (4 regs) versus A path (3 regs).
REQ-018 SHALL hold cur_data and dly_data between beats; cur_valid SHALL be high exactly one cycle per accepted beat.
REQ-019 SHALL delay cur_valid through a COMB_LAT-stage shift register so p_valid is high at T+1+COMB_LAT (T+5 default).
REQ-020 SHALL make dly_data 0 for the first DELAY accepted beats after reset, guaranteed by the CLEAR sweep.
REQ-021 SHALL implement a state machine with two states, CLEAR and RUN.
REQ-022 SHALL in CLEAR write zero to buffer[clr_cnt], increment clr_cnt 0..DELAY-1 each clock, hold s_tready low, and go to RUN after clr_cnt = DELAY-1 (DELAY clocks in CLEAR).
REQ-023 SHALL stay in RUN until reset.
REQ-024 SHALL sustain back-to-back beats at one per clock in RUN.
REQ-025 SHALL treat arithmetic as unsigned pointer arithmetic only; samples pass through bit-exact with no sign handling.

Reset
REQ-026 SHALL on reset_n low asynchronously force state CLEAR, clr_cnt 0, wptr 0, s_tready 0, cur_data 0, dly_data 0, cur_valid 0, and all p_valid pipeline stages 0.
REQ-027 SHALL on reset mid-operation discard in-flight p_valid strobes and re-run the full CLEAR sweep, so no pre-reset sample appears on dly_data.
REQ-028 SHALL release reset synchronously inside the block; the first CLEAR write occurs on the first clock edge with reset_n high.

Structure
REQ-029 SHALL place DELAY, DATA_W, COMB_LAT defaults and the CLEAR/RUN state encoding in the shared channelizer package.
REQ-030 SHALL isolate the buffer in one sub-module, comb_delay_ram, a simple dual-port RAM with 1-cycle registered read and read-first behaviour, inferable as block RAM.

Verification
REQ-031 SHALL verify reset release: s_tready stays 0 for exactly 256 clocks, then goes 1; all outputs stay 0 throughout.
REQ-032 SHALL verify delay fill: feed 512 continuous beats with value k+1 for beat k; dly_data reads 0 for beats 0..255, then 1,2,3...; beat 256 yields cur_data 257 and dly_data 1.
REQ-033 SHALL verify alignment: a single beat at T produces cur_valid at T+1, dly_data updated at T+2, p_valid at T+5, with a comb model giving P = cur - dly.
REQ-034 SHALL verify gaps: random s_tvalid at 30% duty over 1000 beats; each dly_data equals the sample exactly 256 accepted beats earlier, independent of idle cycles.
REQ-035 SHALL verify pointer wrap: after 1024 beats, wptr returns to 0 and dly_data continuity holds across each 255->0 wrap.
REQ-036 SHALL verify mid-run reset: assert reset_n low at beat 300 with p_valid in flight; p_valid drops at once, CLEAR repeats for 256 clocks, and the next 256 dly_data values are 0.
